// File: rtl/sha256_avalon_slave.sv
// Avalon-MM front end for a SHA-256 compression core: message block, control/status,
// start/done handshake guarded by a watchdog, and digest readback.
module sha256_avalon_slave #(
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              core_start,
  output logic              core_init,
  output logic [511:0]      core_block,
  input  logic              core_done,
  input  logic [255:0]      core_digest,
  output logic              irq
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_LATCH} state_t;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(16);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(17);
  localparam logic [ADDR_W-4:0] DIG_TAG  = (ADDR_W-3)'(3);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [31:0]      msg    [16];
  logic [31:0]      digest [8];
  logic             ctrl_init, ctrl_irq_en, sts_done, sts_err;
  logic [CNT_W-1:0] wd_cnt;
  logic             busy, wr_msg, wr_ctrl, wr_status, start_req, launch;
  logic             hw_done, hw_err;
  logic [31:0]      rd_mux;

  always_comb begin
    busy      = (state != S_IDLE);
    wr_msg    = avs_write && (avs_address[ADDR_W-1:4] == '0);
    wr_ctrl   = avs_write && (avs_address == A_CTRL);
    wr_status = avs_write && (avs_address == A_STATUS);
    start_req = wr_ctrl && avs_writedata[0];
    launch    = start_req && (state == S_IDLE);
    hw_done   = (state == S_LATCH);
    // Blocked writes and watchdog expiry both flag ERR; a late core_done beats the watchdog.
    hw_err    = (busy && (wr_msg || start_req)) ||
                ((state == S_WAIT) && !core_done && (wd_cnt == CNT_LAST));
  end

  always_comb begin
    core_block = '0;
    for (int i = 0; i < 16; i++) core_block[511-32*i -: 32] = msg[i];
  end

  always_comb begin
    rd_mux = '0;
    if (avs_address[ADDR_W-1:4] == '0)
      rd_mux = msg[avs_address[3:0]];
    else if (avs_address == A_CTRL)
      rd_mux = {29'd0, ctrl_irq_en, ctrl_init, 1'b0};
    else if (avs_address == A_STATUS)
      rd_mux = {29'd0, sts_err, sts_done, busy};
    else if (avs_address[ADDR_W-1:3] == DIG_TAG)
      rd_mux = digest[avs_address[2:0]];
  end

  assign irq = sts_done && ctrl_irq_en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      core_start <= 1'b0;
      core_init  <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        S_IDLE: if (start_req) begin
          state      <= S_START;
          core_start <= 1'b1;
          core_init  <= avs_writedata[1];
        end
        S_START: begin
          state  <= S_WAIT;
          wd_cnt <= '0;
        end
        S_WAIT: begin
          if (core_done)                state  <= S_LATCH;
          else if (wd_cnt == CNT_LAST)  state  <= S_IDLE;
          else                          wd_cnt <= wd_cnt + 1'b1;
        end
        S_LATCH: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) msg[i] <= '0;
      for (int i = 0; i < 8; i++)  digest[i] <= '0;
      ctrl_init    <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      sts_done     <= 1'b0;
      sts_err      <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (wr_msg && !busy) msg[avs_address[3:0]] <= avs_writedata;
      if (wr_ctrl) begin
        ctrl_init   <= avs_writedata[1];
        ctrl_irq_en <= avs_writedata[2];
      end
      if (hw_done)
        for (int i = 0; i < 8; i++) digest[i] <= core_digest[255-32*i -: 32];
      // Hardware set takes priority over a software write-1-clear in the same cycle.
      if (launch) begin
        sts_done <= 1'b0;
        sts_err  <= 1'b0;
      end else begin
        if (hw_done)                              sts_done <= 1'b1;
        else if (wr_status && avs_writedata[1])   sts_done <= 1'b0;
        if (hw_err)                               sts_err  <= 1'b1;
        else if (wr_status && avs_writedata[2])   sts_err  <= 1'b0;
      end
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sha256_avalon_slave.sv
// Directed bench for sha256_avalon_slave: instance A uses the default watchdog with a
// stub core; instance B uses a 16-cycle watchdog for timeout, race and reset cases.
module tb_sha256_avalon_slave;

  typedef struct {
    logic [31:0] v;
    string       tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [4:0]   avs_address = '0;
  logic [31:0]  avs_writedata = '0;
  logic         avs_write_a = 1'b0, avs_read_a = 1'b0;
  logic         avs_write_b = 1'b0, avs_read_b = 1'b0;
  logic [31:0]  rdata_a, rdata_b;
  logic         core_start_a, core_init_a, irq_a;
  logic         core_start_b, core_init_b, irq_b;
  logic [511:0] core_block_a, core_block_b;
  logic         stub_done_a = 1'b0, stub_done_b = 1'b0, man_done_b = 1'b0;
  logic         core_done_a, core_done_b;
  logic [255:0] digest_a = '0;
  logic [255:0] digest_b = {8{32'h0BADF00D}};

  int stub_lat_a = 0, stub_lat_b = 0;
  int stub_cd_a = 0, stub_cd_b = 0;
  int start_cnt_a = 0, start_cnt_b = 0;
  int checks = 0, failures = 0;

  exp_t rd_q[$];
  exp_t init_q[$];

  assign core_done_a = stub_done_a;
  assign core_done_b = stub_done_b | man_done_b;

  always #5 clk = ~clk;

  sha256_avalon_slave dut_a (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write_a),
    .avs_writedata(avs_writedata), .avs_read(avs_read_a), .avs_readdata(rdata_a),
    .core_start(core_start_a), .core_init(core_init_a), .core_block(core_block_a),
    .core_done(core_done_a), .core_digest(digest_a), .irq(irq_a)
  );

  sha256_avalon_slave #(.ADDR_W(5), .TIMEOUT_CYCLES(16), .CNT_W(5)) dut_b (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write_b),
    .avs_writedata(avs_writedata), .avs_read(avs_read_b), .avs_readdata(rdata_b),
    .core_start(core_start_b), .core_init(core_init_b), .core_block(core_block_b),
    .core_done(core_done_b), .core_digest(digest_b), .irq(irq_b)
  );

  // Stub cores: answer core_start after stub_lat cycles; a latency of 0 never answers.
  always @(posedge clk) begin
    stub_done_a <= 1'b0;
    if (core_start_a) begin
      start_cnt_a <= start_cnt_a + 1;
      if (stub_lat_a > 0) stub_cd_a <= stub_lat_a;
    end else if (stub_cd_a > 0) begin
      stub_cd_a <= stub_cd_a - 1;
      if (stub_cd_a == 1) stub_done_a <= 1'b1;
    end
  end

  always @(posedge clk) begin
    stub_done_b <= 1'b0;
    if (core_start_b) begin
      start_cnt_b <= start_cnt_b + 1;
      if (stub_lat_b > 0) stub_cd_b <= stub_lat_b;
    end else if (stub_cd_b > 0) begin
      stub_cd_b <= stub_cd_b - 1;
      if (stub_cd_b == 1) stub_done_b <= 1'b1;
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel_b, input logic [4:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    if (sel_b) avs_write_b = 1'b1;
    else       avs_write_a = 1'b1;
    step(1);
    avs_write_a = 1'b0;
    avs_write_b = 1'b0;
  endtask

  task automatic rd(input bit sel_b, input logic [4:0] a, input logic [31:0] exp, input string tag);
    exp_t e;
    exp_t got;
    e.v = exp;
    e.tag = tag;
    rd_q.push_back(e);
    avs_address = a;
    if (sel_b) avs_read_b = 1'b1;
    else       avs_read_a = 1'b1;
    step(1);
    avs_read_a = 1'b0;
    avs_read_b = 1'b0;
    got = rd_q.pop_front();
    chk(sel_b ? rdata_b : rdata_a, got.v, got.tag);
  endtask

  // Start write: the pulse must be visible right after the capturing edge.
  task automatic start_op(input bit sel_b, input logic [31:0] ctrl, input string tag);
    exp_t e;
    exp_t got;
    e.v = {31'd0, ctrl[1]};
    e.tag = tag;
    init_q.push_back(e);
    wr(sel_b, 5'h10, ctrl);
    got = init_q.pop_front();
    chk({31'd0, sel_b ? core_start_b : core_start_a}, 32'd1, {got.tag, "_start"});
    chk({31'd0, sel_b ? core_init_b : core_init_a}, got.v, {got.tag, "_init"});
  endtask

  // Wait for the core_done pulse of A, then two more cycles until DONE is registered.
  task automatic wait_done_a(input int bound, input string tag);
    int n = 0;
    while (!core_done_a && n < bound) begin
      step(1);
      n++;
    end
    chk({31'd0, core_done_a}, 32'd1, {tag, "_done_seen"});
    step(2);
  endtask

  initial begin
    int cnt0;
    int j;
    logic [31:0] held;

    step(3);
    reset_n = 1'b1;

    // Reset state
    rd(0, 5'h11, 32'h0, "rst_status");
    rd(0, 5'h18, 32'h0, "rst_h0");
    chk({31'd0, irq_a}, 32'd0, "rst_irq");
    chk(start_cnt_a, 0, "rst_no_start");

    // "abc" single block
    digest_a = 256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
    stub_lat_a = 64;
    wr(0, 5'h00, 32'h61626380);
    for (int i = 1; i < 15; i++) wr(0, 5'(i), 32'h0);
    wr(0, 5'h0F, 32'h00000018);
    start_op(0, 32'h3, "abc");
    chk(core_block_a[511:480], 32'h61626380, "abc_block_w0");
    chk(core_block_a[31:0], 32'h00000018, "abc_block_w15");
    step(1);
    chk({31'd0, core_start_a}, 32'd0, "abc_pulse_width");
    wait_done_a(100, "abc");
    chk(start_cnt_a, 1, "abc_one_start");
    rd(0, 5'h11, 32'h2, "abc_status");
    rd(0, 5'h18, 32'hBA7816BF, "abc_h0");
    rd(0, 5'h1F, 32'hF20015AD, "abc_h7");
    held = rdata_a;
    step(2);
    chk(rdata_a, held, "rd_hold");

    // Chaining with interrupt enabled
    digest_a = {8{32'h13579BDF}};
    start_op(0, 32'h5, "chain");
    wait_done_a(100, "chain");
    chk({31'd0, irq_a}, 32'd1, "chain_irq_up");
    rd(0, 5'h11, 32'h2, "chain_status");
    rd(0, 5'h1A, 32'h13579BDF, "chain_h2");
    wr(0, 5'h11, 32'h2);
    chk({31'd0, irq_a}, 32'd0, "chain_irq_clr");
    rd(0, 5'h11, 32'h0, "chain_status_clr");

    // Busy protection
    stub_lat_a = 40;
    cnt0 = start_cnt_a;
    start_op(0, 32'h1, "busy");
    step(5);
    wr(0, 5'h00, 32'hDEADBEEF);
    wr(0, 5'h10, 32'h1);
    rd(0, 5'h11, 32'h5, "busy_status");
    rd(0, 5'h00, 32'h61626380, "busy_msg0");
    wait_done_a(100, "busy");
    chk(start_cnt_a - cnt0, 1, "busy_no_restart");
    rd(0, 5'h11, 32'h6, "busy_status_end");

    // Timeout on B: first idle STATUS read comes after the start pulse cycle,
    // 16 wait cycles and one cycle of read latency.
    stub_lat_b = 0;
    start_op(1, 32'h1, "tmo");
    avs_address = 5'h11;
    avs_read_b  = 1'b1;
    j = 0;
    do begin
      step(1);
      j++;
    end while (rdata_b[0] && j < 40);
    avs_read_b = 1'b0;
    chk(j, 18, "tmo_busy_drop");
    rd(1, 5'h11, 32'h4, "tmo_status");
    rd(1, 5'h18, 32'h0, "tmo_h0");
    chk(core_block_b[511:480], 32'h0, "b_block_w0");

    // core_done in the watchdog's final cycle: done wins
    stub_lat_b = 15;
    start_op(1, 32'h1, "race");
    step(25);
    rd(1, 5'h11, 32'h2, "race_status");
    rd(1, 5'h18, 32'h0BADF00D, "race_h0");

    // Reset mid-operation, then a stray core_done
    stub_lat_b = 0;
    start_op(1, 32'h1, "mrst");
    step(5);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    man_done_b = 1'b1;
    step(1);
    man_done_b = 1'b0;
    step(3);
    rd(1, 5'h11, 32'h0, "mrst_status");
    rd(1, 5'h18, 32'h0, "mrst_h0");
    chk({31'd0, core_start_b}, 32'd0, "mrst_no_start");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
